// File: rtl/miinst_issue_queue_pkg.sv
// Shared types and defaults for the micro-instruction issue queue.
// Purpose : defines the op encoding (miop_e), the queued record (miinst_t),
//           the canonical NOP record and the default geometry.
// Ports   : none (package).
package miinst_issue_queue_pkg;

  localparam int MIQ_FETCH_W = 4;  // slots per fetch bundle
  localparam int MIQ_DEPTH   = 8;  // queue entries, power of two
  localparam int MIQ_DEQ_W   = 2;  // ops presented to issue per cycle

  typedef enum logic [3:0] {
    MIOP_NOP = 4'd0,
    MIOP_ADD = 4'd1,
    MIOP_SUB = 4'd2,
    MIOP_MUL = 4'd3,
    MIOP_LD  = 4'd4,
    MIOP_ST  = 4'd5,
    MIOP_BR  = 4'd6
  } miop_e;

  typedef struct packed {
    miop_e      op;
    logic [7:0] tag;   // operand / bookkeeping payload carried unchanged
  } miinst_t;

  localparam miinst_t NOP_INST = '{op: MIOP_NOP, tag: 8'h00};

endpackage

// File: rtl/miinst_compactor.sv
// Combinational bundle compactor.
// Purpose : removes every NOP slot from a fetch bundle (interior ones too)
//           and packs the survivors toward slot 0 in original order.
// Ports   : bundle     in  FETCH_W-slot fetch bundle, slot 0 oldest
//           packed_ops out survivors in slots 0..n_in-1, NOP above
//           n_in       out number of non-NOP slots (0..FETCH_W)
module miinst_compactor
  import miinst_issue_queue_pkg::*;
#(
  parameter int FETCH_W = MIQ_FETCH_W,
  localparam int NW = $clog2(FETCH_W + 1)
) (
  input  miinst_t          bundle     [FETCH_W],
  output miinst_t          packed_ops [FETCH_W],
  output logic [NW-1:0]    n_in
);

  // pos[i] = number of non-NOP slots strictly older than slot i, i.e. the
  // destination index of slot i when it survives.
  logic [NW-1:0] pos [FETCH_W];

  always_comb begin
    logic [NW-1:0] run;
    run = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      pos[i] = run;
      run    = run + NW'(bundle[i].op != MIOP_NOP);
    end
    n_in = run;
  end

  // Output slot j picks the unique surviving input whose prefix count is j.
  always_comb begin
    for (int j = 0; j < FETCH_W; j++) begin
      packed_ops[j] = NOP_INST;
      for (int i = 0; i < FETCH_W; i++) begin
        if (bundle[i].op != MIOP_NOP && pos[i] == NW'(j))
          packed_ops[j] = bundle[i];
      end
    end
  end

endmodule

// File: rtl/miinst_issue_queue.sv
// Micro-instruction issue queue (circular buffer with multi-op dequeue).
// Purpose : accepts whole FETCH_W bundles, drops NOP slots, stores survivors
//           in program order and presents up to DEQ_W oldest ops to issue.
// Ports   : clk, rstn (synchronous, active-low), flush (discard contents)
//           fet_miinst/fet_valid/fet_ready : fetch bundle handshake
//           deq_miinst/deq_count           : oldest ops, valid prefix count
//           deq_take                       : ops consumed this cycle
//           q_count                        : current occupancy
// Config  : define MIQ_BYPASS_EN to let a bundle arriving at an empty queue
//           appear on deq_* in the same cycle; otherwise enqueue-to-visible
//           latency is one cycle and deq_* depend only on registered state.
module miinst_issue_queue
  import miinst_issue_queue_pkg::*;
#(
  parameter int FETCH_W = MIQ_FETCH_W,
  parameter int DEPTH   = MIQ_DEPTH,
  parameter int DEQ_W   = MIQ_DEQ_W,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1),
  localparam int NW = $clog2(FETCH_W + 1),
  localparam int DW = $clog2(DEQ_W + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  miinst_t       fet_miinst [FETCH_W],
  input  logic          fet_valid,
  output logic          fet_ready,
  output miinst_t       deq_miinst [DEQ_W],
  output logic [DW-1:0] deq_count,
  input  logic [DW-1:0] deq_take,
  output logic [CW-1:0] q_count
);

  miinst_t       entries [DEPTH];
  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;

  miinst_t       packed_ops [FETCH_W];
  logic [NW-1:0] n_in;

  miinst_compactor #(.FETCH_W(FETCH_W)) u_compactor (
    .bundle     (fet_miinst),
    .packed_ops (packed_ops),
    .n_in       (n_in)
  );

  // Only whole bundles are accepted, so room for FETCH_W is required
  // regardless of how many slots are real ops.
  assign fet_ready = (count_reg <= CW'(DEPTH - FETCH_W));
  assign q_count   = count_reg;

  logic accept;
  assign accept = fet_valid & fet_ready;

  // bypass: the packed bundle is presented directly while the queue is empty.
  logic          bypass;
  logic [CW-1:0] avail;
`ifdef MIQ_BYPASS_EN
  assign bypass = accept && (count_reg == '0);
  assign avail  = bypass ? CW'(n_in) : count_reg;
`else
  assign bypass = 1'b0;
  assign avail  = count_reg;
`endif

  assign deq_count = (avail >= CW'(DEQ_W)) ? DW'(DEQ_W) : DW'(avail);

  for (genvar gi = 0; gi < DEQ_W; gi++) begin : g_deq
    miinst_t src;
`ifdef MIQ_BYPASS_EN
    if (gi < FETCH_W) begin : g_byp
      assign src = bypass ? packed_ops[gi] : entries[head_reg + PW'(gi)];
    end else begin : g_nobyp
      assign src = entries[head_reg + PW'(gi)];
    end
`else
    assign src = entries[head_reg + PW'(gi)];
`endif
    assign deq_miinst[gi] = (DW'(gi) < deq_count) ? src : NOP_INST;
  end

  // Over-consumption is clamped to what is actually presented.
  logic [DW-1:0] take_eff, take_q, skip;
  assign take_eff = (deq_take > deq_count) ? deq_count : deq_take;
  // Bypassed ops taken this cycle never enter storage; the rest pop the head.
  assign take_q   = bypass ? '0 : take_eff;
  assign skip     = bypass ? take_eff : '0;

  logic [NW-1:0] n_wr;
  miinst_t       wr_data [FETCH_W];
  assign n_wr = n_in - NW'(skip);

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      wr_data[i] = NOP_INST;
      for (int j = 0; j < FETCH_W; j++) begin
        if (j == i + int'(skip)) wr_data[i] = packed_ops[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(take_q);
      if (accept) tail_reg <= tail_reg + PW'(n_wr);
      count_reg <= count_reg - CW'(take_q) + (accept ? CW'(n_wr) : '0);
    end
  end

  // Storage is not reset: contents beyond count are never presented.
  always_ff @(posedge clk) begin
    if (rstn && !flush && accept) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (NW'(i) < n_wr) entries[tail_reg + PW'(i)] <= wr_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush) assert (deq_take <= deq_count);
  end

endmodule

// File: doc/miinst_issue_queue.md
Name: miinst_issue_queue

Overview:
- Parametrised successor to the single-head micro-instruction decode queue.
- Receives a FETCH_W-wide bundle of miinst_t from the micro-instruction fetch stage and drops every MIOP_NOP slot, including interior ones.
- Stores the surviving ops in program order in a circular buffer.
- Presents up to DEQ_W oldest ops per cycle to issue, with ready/valid backpressure on the fetch side and a variable consume count on the issue side.

Parameters:
- FETCH_W, 4, slots per fetch bundle (`MQ_N).
- DEPTH, 8, queue entries. Power of two; DEPTH >= FETCH_W and DEPTH >= DEQ_W.
- DEQ_W, 2, ops presented to issue per cycle.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous, active-low reset.
- flush  in  1  discard all queue contents.
- fet_miinst  in  miinst_t[FETCH_W]  fetch bundle; slot 0 is oldest.
- fet_valid  in  1  bundle valid.
- fet_ready  out  1  queue can accept a full bundle.
- deq_miinst  out  miinst_t[DEQ_W]  oldest ops; slot 0 is oldest.
- deq_count  out  $clog2(DEQ_W+1)  number of valid deq_miinst slots; always a prefix.
- deq_take  in  $clog2(DEQ_W+1)  ops consumed by issue this cycle.
- q_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State: entry array, head and tail pointers ($clog2(DEPTH) bits, natural wrap), and registered count.
- Compaction: the n_in non-NOP slots of the bundle (0..FETCH_W) are packed in original order.
- Enqueue: when fet_valid & fet_ready, the packed ops are written at tail..tail+n_in-1 (mod DEPTH) and tail advances by n_in.
- All-NOP bundle: handshake completes, no state change.
- fet_ready = (DEPTH - count) >= FETCH_W.
  - Computed from registered count only; never depends on deq_take or the bundle contents.
  - A bundle is never partially accepted.
- Dequeue outputs:
  - deq_count = min(count, DEQ_W).
  - deq_miinst[k] = entry[head+k] for k < deq_count; otherwise op = MIOP_NOP.
  - Outputs are registered-state based: an op enqueued in cycle t is visible at cycle t+1.
- Consume: head advances by deq_take; count_next = count - deq_take + n_acc, where n_acc = n_in if the handshake occurs, else 0.
  - deq_take > deq_count is illegal. It triggers a simulation assertion and is clamped to deq_count.
  - Simultaneous enqueue and dequeue are both honoured in the same cycle, including when full (no enqueue then) or empty.
- flush: head = tail = count = 0. Concurrent enqueue and dequeue are discarded; flush has priority.
- Reset: same as flush.
  - Reset values: deq_count = 0, all deq_miinst op = MIOP_NOP, q_count = 0, fet_ready = 1.
  - Reset mid-operation loses all contents with no partial state.
- Wrap-around: all pointer arithmetic is mod DEPTH. Ordering across the wrap boundary is preserved.
- Invariant: 0 <= count <= DEPTH. Overflow is impossible by construction of fet_ready.

Optional Feature:
- Macro: MIQ_BYPASS_EN.
- Defined:
  - When count == 0 and a bundle is accepted, the packed ops drive deq_miinst/deq_count combinationally in the same cycle, giving 0-cycle latency.
  - deq_take applies to the bypassed ops. Only the untaken remainder is written, and tail advances by n_in - deq_take.
  - flush still discards everything.
- Undefined: strict 1-cycle enqueue-to-visible latency; no combinational path from fet_* to deq_*.

Decomposition:
- Shared package / common_params: miinst_t, MIOP_NOP, and a new MIQ_DEPTH default plus derived count/pointer width macros.
- Sub-module miinst_compactor (combinational):
  - Inputs: FETCH_W-slot bundle.
  - Outputs: packed array and n_in, via a prefix-popcount of non-NOP flags.
  - Reused by the bypass path and the write path.

Test Plan:
- After reset, bundle {ADD,NOP,SUB,NOP}, fet_valid = 1, deq_take = 0 -> next cycle deq_count = 2, deq_miinst = {ADD,SUB}, q_count = 2.
- Full backpressure:
  - Two 4-op bundles -> q_count = 8, fet_ready = 0, third bundle held.
  - deq_take = 2 for two cycles -> fet_ready = 1 when q_count = 4.
- Wrap-around ordering: 40 ops with random NOP gaps, random deq_take in 0..deq_count -> issued stream equals non-NOP fetch stream in order.
- flush asserted with fet_valid = 1, deq_take = 2, q_count = 5 -> next cycle q_count = 0, deq_count = 0, all deq ops NOP.
- All-NOP bundle accepted at q_count = 3 -> q_count stays 3, pointers unchanged.
- With MIQ_BYPASS_EN, on an empty queue send {MUL,NOP,NOP,NOP} with deq_take = 1 -> same cycle deq_miinst[0] = MUL, next cycle q_count = 0.
